// File: rtl/step_2_ctrl_if.sv
// ---------------------------------------------------------------------------
// step_2_ctrl_if
//
// User request handshake between the input/decode stage and the step-2
// sequencer.
//
//   usr_valid  request valid (driven by the requester)
//   usr_cmd    command: 1 = MOVE, 2 = ROTATE, anything else is a NOP
//   usr_dir    direction: 0 = down, 1 = left/ccw, 2 = right/cw
//   usr_ready  request taken on a cycle where usr_valid & usr_ready
//
// Modports:
//   master  the requester (decode stage)
//   slave   the sequencer (step_2_ctrl)
// ---------------------------------------------------------------------------
interface step_2_ctrl_if #(
    parameter int WIDTH = 8
);

    logic             usr_valid;
    logic [WIDTH-1:0] usr_cmd;
    logic [WIDTH-1:0] usr_dir;
    logic             usr_ready;

    modport master (
        output usr_valid,
        output usr_cmd,
        output usr_dir,
        input  usr_ready
    );

    modport slave (
        input  usr_valid,
        input  usr_cmd,
        input  usr_dir,
        output usr_ready
    );

endinterface

// File: rtl/step_2_ctrl.sv
// ---------------------------------------------------------------------------
// step_2_ctrl
//
// Sequencer for the step-2 move/lock datapath of the tetris CPU. It picks
// either a user move/rotate request or an automatic gravity down-move,
// presents one instruction at a time on instr_step_2, waits one cycle for
// the datapath to compute, samples the collision verdict, and then either
// commits the new coordinates (is_move), locks the piece into the playfield
// bus (is_touch), or drops a colliding user request (rej_pulse).
//
// Ports:
//   clk           system clock, rising edge
//   rst           asynchronous reset, active low
//   run           game enable: gates gravity counting and new acceptance
//   usr           user request handshake (slave side of step_2_ctrl_if)
//   collide       datapath verdict, sampled only in CHECK
//   instr_step_2  {command, dir} to the datapath, 0 while idle
//   is_move       one-cycle commit of the new coordinates
//   is_touch      one-cycle lock of the piece into the bus
//   lock_pulse    one-cycle event: piece locked
//   rej_pulse     one-cycle event: user request rejected by collision
//   busy          high whenever an instruction is in flight
// ---------------------------------------------------------------------------
module step_2_ctrl #(
    parameter int WIDTH          = 8,
    parameter int MEM_WIDTH      = 4,
    parameter int MEM_HEIGHT     = 4,
    parameter int GRAVITY_PERIOD = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 run,
    step_2_ctrl_if.slave         usr,
    input  logic                 collide,
    output logic [2*WIDTH-1:0]   instr_step_2,
    output logic                 is_move,
    output logic                 is_touch,
    output logic                 lock_pulse,
    output logic                 rej_pulse,
    output logic                 busy
);

    // Playfield geometry lives in the datapath; the sequencer only needs the
    // values to be sane so that a mis-parameterised build fails early.
    if (GRAVITY_PERIOD < 2 || MEM_WIDTH < 1 || MEM_HEIGHT < 1) begin : g_param_check
        $error("step_2_ctrl: GRAVITY_PERIOD must be >= 2 and playfield dimensions >= 1");
    end

    localparam int             CNT_W    = (GRAVITY_PERIOD > 2) ? $clog2(GRAVITY_PERIOD) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(GRAVITY_PERIOD - 1);

    localparam logic [WIDTH-1:0] CMD_MOVE   = WIDTH'(1);
    localparam logic [WIDTH-1:0] CMD_ROTATE = WIDTH'(2);
    localparam logic [WIDTH-1:0] DIR_DOWN   = WIDTH'(0);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        CHECK,
        COMMIT,
        LOCK
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  grav_cnt;
    logic              grav_pend;
    logic              src_grav;

    logic              idle;
    logic              grav_issue;
    logic              grav_wrap;
    logic              usr_fire;
    logic              usr_cmd_ok;

    assign idle       = (state == IDLE);
    assign grav_issue = idle & run & grav_pend;
    assign usr_fire   = usr.usr_valid & usr.usr_ready;
    assign usr_cmd_ok = (usr.usr_cmd == CMD_MOVE) | (usr.usr_cmd == CMD_ROTATE);

    // LOCK restarts the gravity interval, so a wrap on that same edge is
    // discarded rather than raising a pending down-move.
    assign grav_wrap  = run & (grav_cnt == CNT_LAST) & (state != LOCK);

    // Gravity holds the user off by dropping ready, which is what gives it
    // priority. rst is folded in so the handshake is quiet during reset.
    assign usr.usr_ready = rst & idle & run & ~grav_pend;

    assign busy = ~idle;

    // Gravity timer: counts enabled cycles in every state, wraps once per
    // period and leaves a single pending request. Further wraps while a
    // request is still pending collapse into that one.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            grav_cnt  <= '0;
            grav_pend <= 1'b0;
        end else begin
            if (state == LOCK) begin
                grav_cnt <= '0;
            end else if (run) begin
                if (grav_cnt == CNT_LAST) begin
                    grav_cnt <= '0;
                end else begin
                    grav_cnt <= grav_cnt + CNT_W'(1);
                end
            end

            if (grav_wrap) begin
                grav_pend <= 1'b1;
            end else if (grav_issue) begin
                grav_pend <= 1'b0;
            end
        end
    end

    // Instruction sequencer. The instruction word is latched on acceptance
    // and held until the machine is back in IDLE; every outcome pulse is
    // registered on the edge that leaves CHECK so it lines up with the
    // COMMIT/LOCK state (or the first IDLE cycle for a rejection).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            src_grav     <= 1'b0;
            instr_step_2 <= '0;
            is_move      <= 1'b0;
            is_touch     <= 1'b0;
            lock_pulse   <= 1'b0;
            rej_pulse    <= 1'b0;
        end else begin
            is_move    <= 1'b0;
            is_touch   <= 1'b0;
            lock_pulse <= 1'b0;
            rej_pulse  <= 1'b0;

            case (state)
                IDLE: begin
                    if (grav_issue) begin
                        instr_step_2 <= {CMD_MOVE, DIR_DOWN};
                        src_grav     <= 1'b1;
                        state        <= ISSUE;
                    end else if (usr_fire && usr_cmd_ok) begin
                        instr_step_2 <= {usr.usr_cmd, usr.usr_dir};
                        src_grav     <= 1'b0;
                        state        <= ISSUE;
                    end
                end

                ISSUE: begin
                    state <= CHECK;
                end

                CHECK: begin
                    if (!collide) begin
                        is_move <= 1'b1;
                        state   <= COMMIT;
                    end else if (src_grav) begin
                        is_touch   <= 1'b1;
                        lock_pulse <= 1'b1;
                        state      <= LOCK;
                    end else begin
                        // A blocked user request (even MOVE down) is simply
                        // dropped; only gravity may lock the piece.
                        rej_pulse    <= 1'b1;
                        instr_step_2 <= '0;
                        state        <= IDLE;
                    end
                end

                COMMIT: begin
                    instr_step_2 <= '0;
                    state        <= IDLE;
                end

                LOCK: begin
                    instr_step_2 <= '0;
                    state        <= IDLE;
                end

                default: begin
                    instr_step_2 <= '0;
                    state        <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_step_2_ctrl.sv
// ---------------------------------------------------------------------------
// tb_step_2_ctrl
//
// Directed bench for step_2_ctrl with GRAVITY_PERIOD = 8. A transaction-level
// model (in-flight phase, modulo gravity timer, pending flag) predicts every
// output each cycle; directed steps pin hand-computed values at known edges.
// Inputs change 1 time unit after a rising edge, directed checks sample 2
// units after it, and the model comparison runs on the falling edge.
// ---------------------------------------------------------------------------
module tb_step_2_ctrl;

    localparam int WIDTH = 8;
    localparam int P     = 8;

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic                run = 1'b0;
    logic                collide = 1'b0;
    logic [2*WIDTH-1:0]  instr_step_2;
    logic                is_move;
    logic                is_touch;
    logic                lock_pulse;
    logic                rej_pulse;
    logic                busy;

    int n_checks = 0;
    int n_pass   = 0;

    step_2_ctrl_if #(.WIDTH(WIDTH)) usr_bus ();

    step_2_ctrl #(
        .WIDTH          (WIDTH),
        .MEM_WIDTH      (4),
        .MEM_HEIGHT     (4),
        .GRAVITY_PERIOD (P)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .run          (run),
        .usr          (usr_bus),
        .collide      (collide),
        .instr_step_2 (instr_step_2),
        .is_move      (is_move),
        .is_touch     (is_touch),
        .lock_pulse   (lock_pulse),
        .rej_pulse    (rej_pulse),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    // One comparison: counts it, and reports it when it does not hold.
    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic apply_stimulus(input logic v, input logic [WIDTH-1:0] c,
                                  input logic [WIDTH-1:0] d, input logic r, input logic col);
        usr_bus.usr_valid = v;
        usr_bus.usr_cmd   = c;
        usr_bus.usr_dir   = d;
        run               = r;
        collide           = col;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Model: phase 0 = idle, 1 = instruction presented, 2 = verdict cycle,
    // 3 = commit or lock cycle. The gravity timer is a modulo-P counter.
    int               m_phase = 0;
    int               m_cnt   = 0;
    bit               m_pend  = 0;
    bit               m_grav  = 0;
    logic [15:0]      m_op    = '0;
    bit               m_move  = 0;
    bit               m_touch = 0;
    bit               m_lock  = 0;
    bit               m_rej   = 0;

    always @(posedge clk or negedge rst) begin : model
        bit lock_now;
        bit take_grav;
        bit take_usr;
        if (!rst) begin
            m_phase <= 0;
            m_cnt   <= 0;
            m_pend  <= 0;
            m_grav  <= 0;
            m_op    <= '0;
            m_move  <= 0;
            m_touch <= 0;
            m_lock  <= 0;
            m_rej   <= 0;
        end else begin
            lock_now  = (m_phase == 3) && m_touch;
            take_grav = (m_phase == 0) && run && m_pend;
            take_usr  = (m_phase == 0) && run && !m_pend && usr_bus.usr_valid &&
                        (usr_bus.usr_cmd == 1 || usr_bus.usr_cmd == 2);
            m_move  <= 0;
            m_touch <= 0;
            m_lock  <= 0;
            m_rej   <= 0;
            if (m_phase == 0) begin
                if (take_grav) begin
                    m_op <= 16'h0100; m_grav <= 1; m_phase <= 1;
                end else if (take_usr) begin
                    m_op <= {usr_bus.usr_cmd, usr_bus.usr_dir}; m_grav <= 0; m_phase <= 1;
                end
            end else if (m_phase == 1) begin
                m_phase <= 2;
            end else if (m_phase == 2) begin
                if (!collide) begin
                    m_move <= 1; m_phase <= 3;
                end else if (m_grav) begin
                    m_touch <= 1; m_lock <= 1; m_phase <= 3;
                end else begin
                    m_rej <= 1; m_op <= '0; m_phase <= 0;
                end
            end else begin
                m_op <= '0; m_phase <= 0;
            end
            if (lock_now)  m_cnt <= 0;
            else if (run)  m_cnt <= (m_cnt + 1) % P;
            if (run && !lock_now && m_cnt == P - 1) m_pend <= 1;
            else if (take_grav)                     m_pend <= 0;
        end
    end

    always @(negedge clk) begin
        check_output("cmp_instr",   32'(instr_step_2), 32'(m_op));
        check_output("cmp_is_move", 32'(is_move),      32'(m_move));
        check_output("cmp_is_touch",32'(is_touch),     32'(m_touch));
        check_output("cmp_lock",    32'(lock_pulse),   32'(m_lock));
        check_output("cmp_rej",     32'(rej_pulse),    32'(m_rej));
        check_output("cmp_busy",    32'(busy),         32'(m_phase != 0));
        check_output("cmp_ready",   32'(usr_bus.usr_ready),
                     32'(rst && m_phase == 0 && run && !m_pend));
        check_output("cmp_exclusive", 32'(is_move & is_touch), 32'd0);
    end

    initial begin
        apply_stimulus(1'b0, 8'd0, 8'd0, 1'b0, 1'b0);
        rst = 1'b0;

        // Reset state.
        tick(1); #1;
        check_output("rst_instr", 32'(instr_step_2), 32'h0);
        check_output("rst_busy",  32'(busy), 32'd0);
        check_output("rst_ready", 32'(usr_bus.usr_ready), 32'd0);
        check_output("rst_move",  32'(is_move), 32'd0);

        // E0: release reset and start the game.
        tick(1);
        rst = 1'b1; run = 1'b1; #1;
        check_output("start_ready", 32'(usr_bus.usr_ready), 32'd1);

        // First gravity: wrap at E8, ISSUE after E9, is_move after E11.
        tick(8); #1;
        check_output("grav1_pend_ready", 32'(usr_bus.usr_ready), 32'd0);
        tick(1); #1;
        check_output("grav1_busy",  32'(busy), 32'd1);
        check_output("grav1_instr", 32'(instr_step_2), 32'h0100);
        tick(2); #1;
        check_output("grav1_move",  32'(is_move), 32'd1);
        tick(1); #1;
        check_output("grav1_move_off", 32'(is_move), 32'd0);
        tick(7); #1;
        check_output("grav2_move_e19", 32'(is_move), 32'd1);

        // User MOVE left: handshake at E21, is_move after E23.
        tick(1);
        apply_stimulus(1'b1, 8'd1, 8'd1, 1'b1, 1'b0); #1;
        check_output("usr_ready_t", 32'(usr_bus.usr_ready), 32'd1);
        tick(1);
        usr_bus.usr_valid = 1'b0; #1;
        check_output("usr_busy_t1",  32'(busy), 32'd1);
        check_output("usr_instr_t1", 32'(instr_step_2), 32'h0101);
        tick(1); #1;
        check_output("usr_instr_t2", 32'(instr_step_2), 32'h0101);
        check_output("usr_move_t2",  32'(is_move), 32'd0);
        tick(1); #1;
        check_output("usr_move_t3",  32'(is_move), 32'd1);
        check_output("usr_instr_t3", 32'(instr_step_2), 32'h0101);
        tick(1); #1;
        check_output("usr_idle_instr", 32'(instr_step_2), 32'h0);
        check_output("usr_idle_ready_pend", 32'(usr_bus.usr_ready), 32'd0);

        // Gravity (ISSUE after E25) with collision -> lock after E27.
        tick(1);
        collide = 1'b1; #1;
        check_output("lock_issue_instr", 32'(instr_step_2), 32'h0100);
        tick(2); #1;
        check_output("lock_touch", 32'(is_touch), 32'd1);
        check_output("lock_pulse", 32'(lock_pulse), 32'd1);
        check_output("lock_no_move", 32'(is_move), 32'd0);
        tick(1);
        collide = 1'b0; #1;
        check_output("lock_touch_off", 32'(is_touch), 32'd0);
        tick(8); #1;
        check_output("relock_wait_busy", 32'(busy), 32'd0);
        tick(1); #1;
        check_output("relock_issue", 32'(instr_step_2), 32'h0100);

        // User ROTATE cw with collision: handshake at E41, rejection after E43.
        tick(3);
        apply_stimulus(1'b1, 8'd2, 8'd2, 1'b1, 1'b1); #1;
        check_output("rot_ready", 32'(usr_bus.usr_ready), 32'd1);
        tick(1);
        usr_bus.usr_valid = 1'b0; #1;
        check_output("rot_instr", 32'(instr_step_2), 32'h0202);
        tick(2); #1;
        check_output("rot_rej",      32'(rej_pulse), 32'd1);
        check_output("rot_busy",     32'(busy), 32'd0);
        check_output("rot_no_touch", 32'(is_touch), 32'd0);
        check_output("rot_ready_again", 32'(usr_bus.usr_ready), 32'd1);

        // E44: gravity pending while a user MOVE right waits.
        tick(1);
        apply_stimulus(1'b1, 8'd1, 8'd2, 1'b1, 1'b0); #1;
        check_output("rot_rej_off", 32'(rej_pulse), 32'd0);
        check_output("prio_ready",  32'(usr_bus.usr_ready), 32'd0);
        tick(1); #1;
        check_output("prio_grav_first", 32'(instr_step_2), 32'h0100);
        tick(2); #1;
        check_output("prio_grav_move", 32'(is_move), 32'd1);
        tick(1); #1;
        check_output("prio_usr_ready", 32'(usr_bus.usr_ready), 32'd1);
        tick(1);
        usr_bus.usr_valid = 1'b0; #1;
        check_output("prio_usr_instr", 32'(instr_step_2), 32'h0102);

        // Reset asserted during CHECK of the gravity issued after E53.
        tick(5);
        rst = 1'b0; #1;
        check_output("midrst_busy",  32'(busy), 32'd0);
        check_output("midrst_instr", 32'(instr_step_2), 32'h0);
        check_output("midrst_ready", 32'(usr_bus.usr_ready), 32'd0);
        tick(1); #1;
        check_output("midrst_no_move",  32'(is_move), 32'd0);
        check_output("midrst_no_touch", 32'(is_touch), 32'd0);
        tick(0);
        rst = 1'b1;
        tick(8); #1;
        check_output("postrst_wait", 32'(busy), 32'd0);
        tick(1); #1;
        check_output("postrst_issue", 32'(instr_step_2), 32'h0100);

        // NOP command is consumed without starting anything.
        tick(3);
        apply_stimulus(1'b1, 8'd3, 8'd0, 1'b1, 1'b0); #1;
        check_output("nop_ready", 32'(usr_bus.usr_ready), 32'd1);
        tick(1);
        usr_bus.usr_valid = 1'b0;
        run = 1'b0; #1;
        check_output("nop_idle", 32'(busy), 32'd0);
        check_output("stop_ready", 32'(usr_bus.usr_ready), 32'd0);

        // run low freezes the timer; on resume the wrap comes 3 edges later,
        // and dropping run mid-flight still lets the move complete.
        tick(10); #1;
        check_output("frozen_busy", 32'(busy), 32'd0);
        tick(0);
        run = 1'b1;
        tick(3); #1;
        check_output("resume_wait", 32'(busy), 32'd0);
        tick(1);
        run = 1'b0; #1;
        check_output("resume_issue", 32'(instr_step_2), 32'h0100);
        tick(2); #1;
        check_output("runoff_move", 32'(is_move), 32'd1);
        tick(4);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
